// File: rtl/alpu_pipe_if.sv
// alpu_pipe_if -- issue/writeback bus of the pipelined ALU.
//
// Request side : valid_i, ready_o, a_i, b_i, instr_i, cin_i
// Result side  : valid_o, ready_i, out_o, cout_o, zero_o, neg_o, ovf_o, illegal_o
// Status       : busy_o (multiplier running)
//
// The master modport is the issuing/consuming side, slave is the ALU itself.
interface alpu_pipe_if #(
    parameter int REG_WIDTH = 8
);
    logic                 valid_i;
    logic                 ready_o;
    logic [REG_WIDTH-1:0] a_i;
    logic [REG_WIDTH-1:0] b_i;
    logic [3:0]           instr_i;
    logic                 cin_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [REG_WIDTH-1:0] out_o;
    logic                 cout_o;
    logic                 zero_o;
    logic                 neg_o;
    logic                 ovf_o;
    logic                 illegal_o;
    logic                 busy_o;

    modport master (
        output valid_i, a_i, b_i, instr_i, cin_i, ready_i,
        input  ready_o, valid_o, out_o, cout_o, zero_o, neg_o, ovf_o, illegal_o, busy_o
    );

    modport slave (
        input  valid_i, a_i, b_i, instr_i, cin_i, ready_i,
        output ready_o, valid_o, out_o, cout_o, zero_o, neg_o, ovf_o, illegal_o, busy_o
    );
endinterface

// File: rtl/alpu_pipe.sv
// alpu_pipe -- registered arithmetic/logic/shift unit with an iterative
// shift-add multiplier, valid/ready handshake on both sides.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    alpu_pipe_if.slave: operands/opcode in, result + flags out
//
// Single-cycle ops land in the output register on the accept edge. MUL
// latches its operands, processes one multiplier bit per clock for
// REG_WIDTH clocks and writes the output register on the last one. The
// input side is closed (ready_o = 0) for the whole multiply.
module alpu_pipe #(
    parameter int REG_WIDTH = 8,
    parameter bit MUL_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    alpu_pipe_if.slave  bus
);
    localparam int SHAMT_W = $clog2(REG_WIDTH);
    localparam int CNT_W   = $clog2(REG_WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                           OP_SHL = 4'h8, OP_SHR = 4'h9, OP_SAR = 4'hA, OP_ROL = 4'hB,
                           OP_MUL = 4'hC, OP_CMP = 4'hD, OP_PSB = 4'hE;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t state_q, state_d;

    logic                   ready_int;
    logic                   busy_int;
    logic                   accept;
    logic                   is_mul;
    logic                   mul_done;

    // output register
    logic [REG_WIDTH-1:0]   out_q, out_d;
    logic                   cout_q, cout_d;
    logic                   zero_q, zero_d;
    logic                   neg_q, neg_d;
    logic                   ovf_q, ovf_d;
    logic                   ill_q, ill_d;
    logic                   valid_q, valid_d;

    // multiplier state
    logic [2*REG_WIDTH-1:0] mcand_q, mcand_d;
    logic [REG_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*REG_WIDTH-1:0] acc_q, acc_d;
    logic [2*REG_WIDTH-1:0] acc_step;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // single-cycle datapath
    logic [SHAMT_W-1:0]     shamt;
    logic [REG_WIDTH-1:0]   add_b;
    logic                   add_c;
    logic [REG_WIDTH:0]     sum;
    logic                   add_ovf;
    logic [REG_WIDTH:0]     shl_w;
    logic [REG_WIDTH:0]     shr_w;
    logic [REG_WIDTH:0]     sar_w;
    logic [2*REG_WIDTH-1:0] rol_w;
    logic [REG_WIDTH-1:0]   res_out;
    logic [REG_WIDTH-1:0]   flag_val;
    logic                   res_cout;
    logic                   res_ovf;
    logic                   res_ill;

    assign accept   = bus.valid_i && ready_int;
    assign is_mul   = MUL_EN && (bus.instr_i == OP_MUL);
    assign mul_done = (state_q == MUL_BUSY) && (cnt_q == CNT_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done)         state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A new op may enter only when the output register is empty or is
    // being drained on this same edge, so MUL always finds it free.
    always_comb begin
        ready_int = (state_q == IDLE) && (!valid_q || bus.ready_i);
        busy_int  = (state_q == MUL_BUSY);
    end

    // ---------------- adder / shifter ----------------
    assign shamt = bus.b_i[SHAMT_W-1:0];

    always_comb begin
        add_b = bus.b_i;
        add_c = 1'b0;
        case (bus.instr_i)
            OP_ADC:         add_c = bus.cin_i;
            OP_SUB, OP_CMP: begin add_b = ~bus.b_i; add_c = 1'b1;      end
            OP_SBC:         begin add_b = ~bus.b_i; add_c = bus.cin_i; end
            default: ;
        endcase
        sum     = {1'b0, bus.a_i} + {1'b0, add_b} + {{REG_WIDTH{1'b0}}, add_c};
        add_ovf = (bus.a_i[REG_WIDTH-1] == add_b[REG_WIDTH-1]) &&
                  (sum[REG_WIDTH-1] != bus.a_i[REG_WIDTH-1]);
    end

    // Shifts are done one bit wider so the last bit shifted out lands in
    // the extra position; a zero shift leaves a 0 there.
    always_comb begin
        shl_w = {1'b0, bus.a_i} << shamt;
        shr_w = {bus.a_i, 1'b0} >> shamt;
        sar_w = $signed({bus.a_i, 1'b0}) >>> shamt;
        rol_w = {bus.a_i, bus.a_i} << shamt;
    end

    always_comb begin
        res_out  = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        res_ill  = 1'b0;
        case (bus.instr_i)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                res_out  = sum[REG_WIDTH-1:0];
                res_cout = sum[REG_WIDTH];
                res_ovf  = add_ovf;
            end
            OP_CMP: begin
                res_out  = bus.a_i;
                res_cout = sum[REG_WIDTH];
                res_ovf  = add_ovf;
            end
            OP_AND: res_out = bus.a_i & bus.b_i;
            OP_OR:  res_out = bus.a_i | bus.b_i;
            OP_XOR: res_out = bus.a_i ^ bus.b_i;
            OP_NOT: res_out = ~bus.a_i;
            OP_PSB: res_out = bus.b_i;
            OP_SHL: begin res_out = shl_w[REG_WIDTH-1:0]; res_cout = shl_w[REG_WIDTH]; end
            OP_SHR: begin res_out = shr_w[REG_WIDTH:1];   res_cout = shr_w[0];         end
            OP_SAR: begin res_out = sar_w[REG_WIDTH:1];   res_cout = sar_w[0];         end
            OP_ROL: begin
                res_out  = rol_w[2*REG_WIDTH-1:REG_WIDTH];
                // the last bit rotated out is the one that wrapped into bit 0
                res_cout = (shamt != '0) && rol_w[REG_WIDTH];
            end
            // MUL never reaches here when enabled; otherwise it is illegal
            default: res_ill = 1'b1;
        endcase
        // CMP reports zero/neg of the difference, not of the passed-through A
        flag_val = (bus.instr_i == OP_CMP) ? sum[REG_WIDTH-1:0] : res_out;
    end

    // ---------------- multiplier step ----------------
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && is_mul) begin
            mcand_d  = {{REG_WIDTH{1'b0}}, bus.a_i};
            mplier_d = bus.b_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(REG_WIDTH);
        end else if (state_q == MUL_BUSY) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    // ---------------- output register ----------------
    always_comb begin
        out_d   = out_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        valid_d = valid_q;
        if (mul_done) begin
            out_d   = acc_step[REG_WIDTH-1:0];
            cout_d  = |acc_step[2*REG_WIDTH-1:REG_WIDTH];
            zero_d  = (acc_step[REG_WIDTH-1:0] == '0);
            neg_d   = acc_step[REG_WIDTH-1];
            ovf_d   = 1'b0;
            ill_d   = 1'b0;
            valid_d = 1'b1;
        end else if (accept && !is_mul) begin
            out_d   = res_out;
            cout_d  = res_cout;
            zero_d  = (flag_val == '0);
            neg_d   = flag_val[REG_WIDTH-1];
            ovf_d   = res_ovf;
            ill_d   = res_ill;
            valid_d = 1'b1;
        end else if (accept || (valid_q && bus.ready_i)) begin
            // drained, and either nothing new or a MUL that starts now
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            valid_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            out_q    <= out_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            valid_q  <= valid_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ready_o   = ready_int;
    assign bus.busy_o    = busy_int;
    assign bus.valid_o   = valid_q;
    assign bus.out_o     = out_q;
    assign bus.cout_o    = cout_q;
    assign bus.zero_o    = zero_q;
    assign bus.neg_o     = neg_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.illegal_o = ill_q;
endmodule

// File: tb/tb_alpu_pipe.sv
// tb_alpu_pipe -- self-checking bench for alpu_pipe (REG_WIDTH=8, MUL_EN=1).
// A transaction-level model (result FIFO + multiply countdown) predicts
// valid/ready/busy every cycle and the result/flags of every operation.
module tb_alpu_pipe;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alpu_pipe_if #(.REG_WIDTH(W)) bus ();

    alpu_pipe #(.REG_WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         cout;
        logic         zero;
        logic         neg;
        logic         ovf;
        logic         ill;
    } res_t;

    res_t exp_q[$];
    res_t mul_res;
    int   mul_left = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    logic         d_valid, d_ready, d_cin, d_reset;
    logic [3:0]   d_op;
    logic [W-1:0] d_a, d_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference: integer arithmetic and bit-by-bit shift loops.
    function automatic res_t ref_op(input logic [3:0] op, input logic [W-1:0] av,
                                    input logic [W-1:0] bv, input logic cin);
        res_t res;
        int a, b, sa, sb, r, sr, x, c, sh, p;
        bit arith;
        a = int'(av); b = int'(bv); sa = to_signed(a); sb = to_signed(b);
        sh = b % W; r = 0; sr = 0; c = 0; arith = 0;
        res.op = op; res.a = av; res.b = bv; res.ill = 1'b0; res.ovf = 1'b0;
        case (op)
            4'h0: begin r = a + b;               sr = sa + sb;             arith = 1; end
            4'h1: begin r = a + b + cin;         sr = sa + sb + cin;       arith = 1; end
            4'h2, 4'hD:
                  begin r = a + (M - 1 - b) + 1; sr = sa - sb;             arith = 1; end
            4'h3: begin r = a + (M - 1 - b) + cin; sr = sa - sb - 1 + cin; arith = 1; end
            4'h4: r = a & b;
            4'h5: r = a | b;
            4'h6: r = a ^ b;
            4'h7: r = M - 1 - a;
            4'h8: begin x = a; for (int i = 0; i < sh; i++) begin c = (x >> (W-1)) & 1; x = (x << 1) % M; end r = x; end
            4'h9: begin x = a; for (int i = 0; i < sh; i++) begin c = x & 1; x = x >> 1; end r = x; end
            4'hA: begin x = a; for (int i = 0; i < sh; i++) begin c = x & 1; x = (x >> 1) | (x & (M/2)); end r = x; end
            4'hB: begin x = a; for (int i = 0; i < sh; i++) begin c = (x >> (W-1)) & 1; x = ((x << 1) % M) | c; end r = x; end
            4'hC: begin p = a * b; r = p % M; c = (p >= M) ? 1 : 0; end
            4'hE: r = b;
            default: res.ill = 1'b1;
        endcase
        if (arith) begin
            c = (r >= M) ? 1 : 0;
            r = r % M;
            res.ovf = (sr >= M / 2) || (sr < -(M / 2));
        end
        res.cout = c[0];
        res.zero = (r == 0);
        res.neg  = (r >= M / 2);
        res.out  = (op == 4'hD) ? av : W'(r);
        return res;
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, then advance
    // the model to what the coming rising edge should do.
    task automatic cycle();
        logic exp_valid, exp_ready;
        res_t h, r;
        @(negedge clk);
        reset       = d_reset;
        bus.valid_i = d_valid;
        bus.a_i     = d_a;
        bus.b_i     = d_b;
        bus.instr_i = d_op;
        bus.cin_i   = d_cin;
        bus.ready_i = d_ready;
        #1;
        exp_valid = (exp_q.size() > 0);
        exp_ready = (mul_left == 0) && (!exp_valid || d_ready);
        check_val("valid_o", bus.valid_o, exp_valid);
        check_val("ready_o", bus.ready_o, exp_ready);
        check_val("busy_o", bus.busy_o, mul_left > 0);
        if (exp_valid) begin
            h = exp_q[0];
            check_val("out_o", bus.out_o, h.out);
            check_val("cout_o", bus.cout_o, h.cout);
            check_val("zero_o", bus.zero_o, h.zero);
            check_val("neg_o", bus.neg_o, h.neg);
            check_val("ovf_o", bus.ovf_o, h.ovf);
            check_val("illegal_o", bus.illegal_o, h.ill);
        end
        if (d_reset) begin
            exp_q.delete();
            mul_left = 0;
        end else begin
            if (exp_valid && d_ready) begin
                h = exp_q.pop_front();
                n_txn++;
                $display("txn %0d op=%h a=%h b=%h -> out=%h c=%b z=%b n=%b v=%b ill=%b",
                         n_txn, h.op, h.a, h.b, h.out, h.cout, h.zero, h.neg, h.ovf, h.ill);
            end
            if (d_valid && exp_ready) begin
                r = ref_op(d_op, d_a, d_b, d_cin);
                if (d_op == 4'hC) begin
                    mul_left = W;
                    mul_res  = r;
                end else begin
                    exp_q.push_back(r);
                end
            end else if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) exp_q.push_back(mul_res);
            end
        end
    endtask

    // Issue one op into an idle unit, wait (bounded) for its result and
    // check it against hand-computed values.
    task automatic directed(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin, input logic [W-1:0] e_out,
                            input logic e_cout, input logic e_zero, input logic e_neg,
                            input logic e_ovf, input logic e_ill, input int e_lat);
        int waited;
        d_valid = 1'b1; d_op = op; d_a = a; d_b = b; d_cin = cin; d_ready = 1'b1; d_reset = 1'b0;
        cycle();
        d_valid = 1'b0;
        waited  = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            waited++;
            if (bus.valid_o) break;
        end
        check_val({tag, "_lat"}, waited, e_lat);
        check_val({tag, "_out"}, bus.out_o, e_out);
        check_val({tag, "_cout"}, bus.cout_o, e_cout);
        check_val({tag, "_zero"}, bus.zero_o, e_zero);
        check_val({tag, "_neg"}, bus.neg_o, e_neg);
        check_val({tag, "_ovf"}, bus.ovf_o, e_ovf);
        check_val({tag, "_ill"}, bus.illegal_o, e_ill);
    endtask

    initial begin
        reset = 1'b1;
        bus.valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.instr_i = '0;
        bus.cin_i = 1'b0; bus.ready_i = 1'b1;
        d_valid = 1'b0; d_ready = 1'b1; d_cin = 1'b0; d_reset = 1'b0;
        d_op = '0; d_a = '0; d_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", bus.valid_o, 0);
        check_val("rst_ready", bus.ready_o, 1);
        check_val("rst_busy", bus.busy_o, 0);
        check_val("rst_out", bus.out_o, 0);
        check_val("rst_flags", {bus.cout_o, bus.zero_o, bus.neg_o, bus.ovf_o, bus.illegal_o}, 0);

        // op      a     b     cin out   cout zero neg ovf ill lat
        directed("add",  4'h0, 8'hFF, 8'h01, 0, 8'h00, 1, 1, 0, 0, 0, 1);
        directed("sub",  4'h2, 8'h80, 8'h01, 0, 8'h7F, 1, 0, 0, 1, 0, 1);
        directed("cmp",  4'hD, 8'h05, 8'h05, 0, 8'h05, 1, 1, 0, 0, 0, 1);
        directed("sar",  4'hA, 8'h90, 8'h05, 0, 8'hFC, 1, 0, 1, 0, 0, 1);
        directed("rol",  4'hB, 8'h90, 8'h00, 0, 8'h90, 0, 0, 1, 0, 0, 1);
        directed("mul1", 4'hC, 8'h13, 8'h0B, 0, 8'hD1, 0, 0, 1, 0, 0, 9);
        directed("mul2", 4'hC, 8'h20, 8'h10, 0, 8'h00, 1, 1, 0, 0, 0, 9);
        directed("ill",  4'hF, 8'h12, 8'h34, 1, 8'h00, 0, 1, 0, 0, 1, 1);

        // streaming at full rate, then a three-cycle stall
        d_ready = 1'b1; d_valid = 1'b1; d_op = 4'h0; d_cin = 1'b0;
        d_a = 8'h01; d_b = 8'h01; cycle();
        d_a = 8'h02; d_b = 8'h02; cycle();
        check_val("stream0", bus.out_o, 8'h02);
        d_a = 8'h03; d_b = 8'h03; cycle();
        check_val("stream1", bus.out_o, 8'h04);
        d_a = 8'h07; d_b = 8'h07; d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("stall_out", bus.out_o, 8'h06);
            check_val("stall_rdy", bus.ready_o, 0);
        end
        d_ready = 1'b1; cycle();
        check_val("release_rdy", bus.ready_o, 1);
        d_valid = 1'b0; cycle();
        check_val("release_out", bus.out_o, 8'h0E);

        // reset three cycles into a multiply
        d_valid = 1'b1; d_op = 4'hC; d_a = 8'h13; d_b = 8'h0B; cycle();
        d_valid = 1'b0;
        repeat (3) cycle();
        check_val("mid_mul_busy", bus.busy_o, 1);
        d_reset = 1'b1; cycle();
        d_reset = 1'b0; cycle();
        check_val("abort_valid", bus.valid_o, 0);
        check_val("abort_ready", bus.ready_o, 1);
        check_val("abort_busy", bus.busy_o, 0);
        check_val("abort_out", bus.out_o, 0);
        check_val("abort_flags", {bus.cout_o, bus.zero_o, bus.neg_o, bus.ovf_o, bus.illegal_o}, 0);
        repeat (12) cycle();

        // randomized traffic with occasional resets
        for (int n = 0; n < 2500; n++) begin
            d_reset = ($urandom_range(0, 299) == 0);
            d_valid = ($urandom_range(0, 9) < 7);
            d_ready = ($urandom_range(0, 3) != 0);
            d_op    = 4'($urandom_range(0, 15));
            d_cin   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       d_a = 8'h00;
                1:       d_a = 8'hFF;
                2:       d_a = 8'h80;
                3:       d_a = 8'h7F;
                default: d_a = 8'($urandom);
            endcase
            d_b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            cycle();
        end

        d_reset = 1'b0; d_valid = 1'b0; d_ready = 1'b1;
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alpu_pipe.md
Name: alpu_pipe

Overview:
Parametrised successor to the 4-bit combinational ALPU: a registered arithmetic/logic/shift unit with a valid/ready handshake on both sides and a full flag set. It adds an iterative shift-add multiplier that takes REG_WIDTH cycles. It sits between the issue stage and writeback. Single-cycle ops stream at one per clock; MUL stalls the input side while it runs.

Parameters:
REG_WIDTH, 8, operand/result width; power of 2, at least 4.
MUL_EN, 1, enables MUL; when 0, opcode 0xC is illegal.
SHAMT_W, $clog2(REG_WIDTH), derived localparam; shift amount is b_i[SHAMT_W-1:0].

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
valid_i  input  1  operation presented.
ready_o  output  1  unit can accept; transfer occurs when valid_i && ready_o.
a_i  input  REG_WIDTH  operand A.
b_i  input  REG_WIDTH  operand B or shift amount.
instr_i  input  4  opcode.
cin_i  input  1  carry in; used by ADC and SBC only.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
out_o  output  REG_WIDTH  result.
cout_o  output  1  carry / shifted-out bit / MUL high-half-nonzero.
zero_o  output  1  out_o == 0.
neg_o  output  1  out_o[REG_WIDTH-1].
ovf_o  output  1  signed overflow.
illegal_o  output  1  opcode was illegal.
busy_o  output  1  MUL in progress.

Behaviour:
- Reset takes priority over all other activity:
  - all outputs 0, except ready_o, which is 1 on the first cycle after reset;
  - state goes to IDLE;
  - an in-flight MUL is aborted and no result is produced.
- Opcodes and results:
  - 0 ADD: a+b.
  - 1 ADC: a+b+cin.
  - 2 SUB: a+~b+1.
  - 3 SBC: a+~b+cin.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~a.
  - 8 SHL, 9 SHR (logical), A SAR, B ROL: shift a by b[SHAMT_W-1:0].
  - C MUL: low REG_WIDTH bits of a*b, unsigned.
  - D CMP: computes flags as SUB, but out_o = a.
  - E PASSB: b.
  - F: illegal.
- Flags:
  - Add/sub/CMP: cout = carry out of the REG_WIDTH adder; ovf = standard two's-complement overflow.
  - Logic/PASSB: cout = 0, ovf = 0.
  - Shifts: cout = last bit shifted or rotated out (0 if shift amount is 0); ovf = 0.
  - MUL: cout = 1 iff high half of the product is nonzero; ovf = 0.
  - Illegal opcode: out = 0, illegal_o = 1, zero_o = 1, other flags 0.
  - zero_o and neg_o always reflect out_o, except for CMP, where they reflect the SUB result.
- FSM states: IDLE, MUL_BUSY.
- Output register: holds result and flags; valid_o is its occupancy bit.
- ready_o = (state == IDLE) && (!valid_o || ready_i).
- Single-cycle op accepted at edge T: result and flags registered at T, valid_o = 1 immediately after T (latency 1). Back-to-back accepts give full throughput when ready_i = 1.
- MUL accepted at edge T:
  - state goes to MUL_BUSY and busy_o = 1; operands are latched and a counter is loaded with REG_WIDTH.
  - One partial-product bit is processed per cycle.
  - On the REG_WIDTH-th subsequent edge the result is written, valid_o = 1, and state returns to IDLE (latency REG_WIDTH+1 edges).
  - ready_o = 0 throughout MUL_BUSY.
- MUL entry condition: MUL is only accepted when the output register is empty or being drained that cycle. The result register is therefore always free at MUL completion.
- Stall: while valid_o && !ready_i, out_o and all flags hold stable and ready_o = 0.
- Simultaneous drain and accept (valid_o && ready_i && valid_i in IDLE): old result is consumed and the new result loads on the same edge; valid_o stays 1.
- valid_o falls only on an edge where ready_i = 1 and no new single-cycle op is accepted.
- Inputs are sampled only at accept; changes afterwards, including during MUL, are ignored.
- MUL_EN = 0: 0xC behaves as 0xF, with single-cycle latency.

Test Plan:
Each scenario below uses REG_WIDTH=8, MUL_EN=1.
1. ADD a=0xFF b=0x01 -> 1 cycle later valid_o=1, out=0x00, cout=1, zero=1, ovf=0, neg=0.
2. SUB a=0x80 b=0x01 -> out=0x7F, cout=1, ovf=1, neg=0; then CMP a=0x05 b=0x05 -> out=0x05, zero=1, cout=1.
3. Shifts with a=0x90:
   - SAR, b=5 -> out=0xFC, cout=1, neg=1.
   - ROL, b=0 -> out=0x90, cout=0.
4. MUL a=0x13 b=0x0B -> ready_o=0 and busy_o=1 for 8 cycles, valid_o after 9 edges, out=0xD1, cout=0. Then MUL 0x20*0x10 -> out=0x00, cout=1, zero=1.
5. Streaming and stall:
   - Stream ADD 1+1, 2+2, 3+3 with ready_i=1 -> out 0x02, 0x04, 0x06 on consecutive cycles.
   - Hold ready_i=0 -> ready_o=0 and outputs frozen for 3 cycles; release -> next op accepted the same cycle.
6. Reset and illegal opcode:
   - Assert reset 3 cycles into a MUL -> next cycle all outputs 0, ready_o=1, no result ever appears.
   - instr=0xF -> out=0, illegal_o=1, zero=1.
